// File: rtl/sdram_word_requester.sv
// Splits 32-bit host word commands into two big-endian 16-bit four-phase
// handshakes on the SDRAM controller write/read ports, with per-phase timeout.
module sdram_word_requester #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_rsp_valid,
    output logic        host_rsp_err,
    output logic [31:0] host_rdata,
    output logic        writeport_wr,
    output logic [31:0] writeport_addr,
    output logic [15:0] writeport_data,
    input  logic        writeport_ack,
    output logic        readport_rd,
    output logic [31:0] readport_addr,
    input  logic [15:0] readport_data,
    input  logic        readport_ack
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_HI_REQ, S_HI_REL, S_LO_REQ, S_LO_REL, S_RESP, S_ERR, S_DRAIN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:1]      r_base;
    logic [15:0]      r_wdata_lo;
    logic [15:0]      r_rd_hi;
    logic [15:0]      r_rd_lo;
    logic             r_wr;
    logic             r_rd;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [31:0]      r_rdata;
    logic [31:0]      r_port_addr;
    logic [15:0]      r_port_data;

    logic w_ack;
    logic w_is_req;
    logic w_exit;
    logic w_timeout;
    logic w_unused_addr_lsb;

    // Address bit 0 is forced to zero on the halfword base.
    assign w_unused_addr_lsb = host_addr[0];

    assign w_ack     = r_we ? writeport_ack : readport_ack;
    assign w_is_req  = (r_state == S_HI_REQ) || (r_state == S_LO_REQ);
    assign w_exit    = w_is_req ? w_ack : ~w_ack;
    assign w_timeout = TIMEOUT_EN && (r_cnt == CNT_LAST);

    // Never accept while the controller still holds an ack from an aborted access.
    assign host_req_ready = (r_state == S_IDLE) && !writeport_ack && !readport_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_port_addr <= '0;
            r_port_data <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host_req_valid && host_req_ready) begin
                        r_we        <= host_we;
                        r_base      <= host_addr[31:1];
                        r_wdata_lo  <= host_wdata[15:0];
                        r_port_addr <= {host_addr[31:1], 1'b0};
                        if (host_we) begin
                            r_port_data <= host_wdata[31:16];
                        end
                        r_wr        <= host_we;
                        r_rd        <= ~host_we;
                        r_cnt       <= '0;
                        r_state     <= S_HI_REQ;
                    end
                end
                S_HI_REQ, S_HI_REL, S_LO_REQ, S_LO_REL: begin
                    if (w_exit) begin
                        r_cnt <= '0;
                        if (r_state == S_HI_REQ) begin
                            if (!r_we) begin
                                r_rd_hi <= readport_data;
                            end
                            r_wr    <= 1'b0;
                            r_rd    <= 1'b0;
                            r_state <= S_HI_REL;
                        end else if (r_state == S_LO_REQ) begin
                            if (!r_we) begin
                                r_rd_lo <= readport_data;
                            end
                            r_wr    <= 1'b0;
                            r_rd    <= 1'b0;
                            r_state <= S_LO_REL;
                        end else if (r_state == S_HI_REL) begin
                            r_port_addr <= {r_base, 1'b1};
                            if (r_we) begin
                                r_port_data <= r_wdata_lo;
                            end
                            r_wr    <= r_we;
                            r_rd    <= ~r_we;
                            r_state <= S_LO_REQ;
                        end else begin
                            if (!r_we) begin
                                r_rdata <= {r_rd_hi, r_rd_lo};
                            end
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        r_wr        <= 1'b0;
                        r_rd        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rdata     <= '0;
                        r_state     <= S_ERR;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (!writeport_ack && !readport_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host_rsp_valid = r_rsp_valid;
    assign host_rsp_err   = r_rsp_err;
    assign host_rdata     = r_rdata;
    assign writeport_wr   = r_wr;
    assign writeport_addr = r_port_addr;
    assign writeport_data = r_port_data;
    assign readport_rd    = r_rd;
    assign readport_addr  = r_port_addr;

endmodule

// File: tb/tb_sdram_word_requester.sv
// Scoreboard bench for sdram_word_requester: a configurable ack responder,
// handshake/response monitors, and one task per scenario.
module tb_sdram_word_requester;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req_valid = 1'b0;
    logic        host_req_ready;
    logic        host_we = 1'b0;
    logic [31:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_rsp_valid;
    logic        host_rsp_err;
    logic [31:0] host_rdata;
    logic        writeport_wr;
    logic [31:0] writeport_addr;
    logic [15:0] writeport_data;
    logic        wack = 1'b0;
    logic        readport_rd;
    logic [31:0] readport_addr;
    logic [15:0] readport_data;
    logic        rack = 1'b0;

    logic resp_en = 1'b1;
    logic man_wack = 1'b0;
    logic man_rack = 1'b0;
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {logic err; logic [31:0] rdata; logic [31:0] cyc;} rsp_t;
    typedef struct packed {logic err; logic [31:0] rdata;} exp_t;
    typedef struct packed {logic is_wr; logic [31:0] waddr; logic [31:0] raddr; logic [15:0] wdata;} hs_t;

    rsp_t rsp_q[$];
    exp_t exp_q[$];
    hs_t  hs_q[$];

    sdram_word_requester #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_err   (host_rsp_err),
        .host_rdata     (host_rdata),
        .writeport_wr   (writeport_wr),
        .writeport_addr (writeport_addr),
        .writeport_data (writeport_data),
        .writeport_ack  (wack),
        .readport_rd    (readport_rd),
        .readport_addr  (readport_addr),
        .readport_data  (readport_data),
        .readport_ack   (rack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: ack follows request one cycle later, or manual control.
    always @(posedge clk) begin
        if (resp_en) begin
            wack <= writeport_wr;
            rack <= readport_rd;
        end else begin
            wack <= man_wack;
            rack <= man_rack;
        end
    end

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 16'hCAFE;
            32'h0000_0041: return 16'hF00D;
            32'h0000_0300: return 16'h1357;
            32'h0000_0301: return 16'h9BDF;
            default:       return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    assign readport_data = rack ? mem_rd(readport_addr) : 16'h0000;

    always @(negedge clk) begin
        wr_prev <= writeport_wr;
        rd_prev <= readport_rd;
        if (writeport_wr && !wr_prev)
            hs_q.push_back(hs_t'{1'b1, writeport_addr, readport_addr, writeport_data});
        if (readport_rd && !rd_prev)
            hs_q.push_back(hs_t'{1'b0, writeport_addr, readport_addr, writeport_data});
        if (host_rsp_valid)
            rsp_q.push_back(rsp_t'{host_rsp_err, host_rdata, 32'(cyc)});
    end

    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int t_acc, output bit ok);
        ok = 1'b0;
        t_acc = -1;
        host_req_valid = 1'b1;
        host_we = we;
        host_addr = addr;
        host_wdata = wdata;
        for (int k = 0; k < 64; k++) begin
            #1;
            if (host_req_ready) begin
                ok = 1'b1;
                t_acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        host_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (rsp_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (writeport_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", writeport_wr); end
        checks++; if (readport_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", readport_rd); end
        checks++; if (host_rsp_valid !== 1'b0 || host_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b%b expected 00", host_rsp_valid, host_rsp_err); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", host_rdata); end
        checks++; if (writeport_addr !== 32'h0 || readport_addr !== 32'h0 || writeport_data !== 16'h0) begin errors++; $display("FAIL reset_port: got %h/%h/%h expected 0", writeport_addr, readport_addr, writeport_data); end
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", host_req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int t_acc;
        bit ok;
        int br;
        int bh;
        exp_t e;
        br = rsp_q.size();
        bh = hs_q.size();
        exp_q.push_back(exp_t'{1'b0, 32'h0});
        do_cmd(1'b1, 32'h0000_1235, 32'hDEAD_BEEF, t_acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_accept: got no accept expected accept"); end
        wait_rsp(br + 1, ok);
        e = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL write_rsp: got none expected one response"); end
        if (ok) begin
            checks++; if (rsp_q[br].err !== e.err) begin errors++; $display("FAIL write_err: got %b expected %b", rsp_q[br].err, e.err); end
            checks++; if (int'(rsp_q[br].cyc) - t_acc !== 9) begin errors++; $display("FAIL write_latency: got %0d expected 9", int'(rsp_q[br].cyc) - t_acc); end
        end
        checks++;
        if (hs_q.size() - bh !== 2) begin
            errors++; $display("FAIL write_hs_count: got %0d expected 2", hs_q.size() - bh);
        end else begin
            if (hs_q[bh] !== hs_t'{1'b1, 32'h1234, 32'h1234, 16'hDEAD}) begin errors++; $display("FAIL write_hs_hi: got %h expected %h", hs_q[bh], hs_t'{1'b1, 32'h1234, 32'h1234, 16'hDEAD}); end
            checks++;
            if (hs_q[bh+1] !== hs_t'{1'b1, 32'h1235, 32'h1235, 16'hBEEF}) begin errors++; $display("FAIL write_hs_lo: got %h expected %h", hs_q[bh+1], hs_t'{1'b1, 32'h1235, 32'h1235, 16'hBEEF}); end
        end
        @(negedge clk);
        #1;
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL write_ready_again: got %b expected 1", host_req_ready); end
    endtask

    task automatic test_read();
        int t_acc;
        bit ok;
        int br;
        int bh;
        exp_t e;
        br = rsp_q.size();
        bh = hs_q.size();
        exp_q.push_back(exp_t'{1'b0, 32'hCAFE_F00D});
        do_cmd(1'b0, 32'h0000_0040, 32'h0, t_acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_accept: got no accept expected accept"); end
        wait_rsp(br + 1, ok);
        e = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL read_rsp: got none expected one response"); end
        if (ok) begin
            checks++; if (rsp_q[br].rdata !== e.rdata || rsp_q[br].err !== e.err) begin errors++; $display("FAIL read_data: got %h err %b expected %h err %b", rsp_q[br].rdata, rsp_q[br].err, e.rdata, e.err); end
            checks++; if (int'(rsp_q[br].cyc) - t_acc !== 9) begin errors++; $display("FAIL read_latency: got %0d expected 9", int'(rsp_q[br].cyc) - t_acc); end
        end
        checks++;
        if (hs_q.size() - bh !== 2) begin
            errors++; $display("FAIL read_hs_count: got %0d expected 2", hs_q.size() - bh);
        end else begin
            if (hs_q[bh].is_wr !== 1'b0 || hs_q[bh].raddr !== 32'h40 || hs_q[bh].waddr !== 32'h40) begin errors++; $display("FAIL read_hs_hi: got %h expected read at 40/40", hs_q[bh]); end
            checks++;
            if (hs_q[bh+1].is_wr !== 1'b0 || hs_q[bh+1].raddr !== 32'h41 || hs_q[bh+1].waddr !== 32'h41) begin errors++; $display("FAIL read_hs_lo: got %h expected read at 41/41", hs_q[bh+1]); end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int t_acc;
        bit ok;
        int br;
        int bh;
        int rd_cnt;
        exp_t e;
        resp_en = 1'b0;
        man_rack = 1'b0;
        man_wack = 1'b0;
        br = rsp_q.size();
        bh = hs_q.size();
        rd_cnt = 0;
        exp_q.push_back(exp_t'{1'b1, 32'h0});
        do_cmd(1'b0, 32'h0000_0080, 32'h0, t_acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_accept: got no accept expected accept"); end
        for (int k = 0; k < 40; k++) begin
            #1;
            if (readport_rd) rd_cnt++;
            if (rsp_q.size() > br) break;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++; if (rd_cnt !== TO) begin errors++; $display("FAIL timeout_rd_cycles: got %0d expected %0d", rd_cnt, TO); end
        checks++;
        if (rsp_q.size() <= br) begin
            errors++; $display("FAIL timeout_rsp: got none expected error response");
        end else begin
            if (rsp_q[br].err !== e.err || rsp_q[br].rdata !== e.rdata) begin errors++; $display("FAIL timeout_err: got err %b data %h expected err %b data %h", rsp_q[br].err, rsp_q[br].rdata, e.err, e.rdata); end
            checks++;
            if (int'(rsp_q[br].cyc) - t_acc !== 9) begin errors++; $display("FAIL timeout_latency: got %0d expected 9", int'(rsp_q[br].cyc) - t_acc); end
        end
        @(negedge clk);
        #1;
        checks++; if (host_req_ready !== 1'b0) begin errors++; $display("FAIL timeout_drain_ready: got %b expected 0", host_req_ready); end
        @(negedge clk);
        #1;
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle_ready: got %b expected 1", host_req_ready); end
        checks++; if (hs_q.size() - bh !== 1) begin errors++; $display("FAIL timeout_hs_count: got %0d expected 1", hs_q.size() - bh); end
    endtask

    task automatic test_late_ack();
        int t_acc;
        bit ok;
        int br;
        int bh;
        int ready_bad;
        resp_en = 1'b0;
        man_rack = 1'b0;
        br = rsp_q.size();
        bh = hs_q.size();
        ready_bad = 0;
        do_cmd(1'b0, 32'h0000_0090, 32'h0, t_acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL late_accept: got no accept expected accept"); end
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rsp_q.size() > br) break;
            @(negedge clk);
        end
        checks++; if (rsp_q.size() !== br + 1 || rsp_q[br].err !== 1'b1) begin errors++; $display("FAIL late_err_rsp: got %0d responses expected one error response", rsp_q.size() - br); end
        man_rack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (host_req_ready) ready_bad++;
            if (k == 4) man_rack = 1'b0;
        end
        checks++; if (ready_bad !== 0) begin errors++; $display("FAIL late_ready_held: got %0d ready cycles expected 0", ready_bad); end
        @(negedge clk);
        #1;
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL late_ready_rise: got %b expected 1", host_req_ready); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rsp_q.size() - br !== 1 || hs_q.size() - bh !== 1) begin errors++; $display("FAIL late_single_rsp: got %0d rsp %0d hs expected 1 rsp 1 hs", rsp_q.size() - br, hs_q.size() - bh); end
        resp_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        bit ok;
        bit found;
        int br;
        int bh;
        exp_t e;
        resp_en = 1'b1;
        br = rsp_q.size();
        bh = hs_q.size();
        found = 1'b0;
        do_cmd(1'b1, 32'h0000_0200, 32'h1111_2222, t1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_accept: got no accept expected accept"); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (writeport_wr && writeport_addr === 32'h201 && wack) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_lo_req: got no LO_REQ with ack expected one"); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (writeport_wr !== 1'b0 || readport_rd !== 1'b0) begin errors++; $display("FAIL abort_req_drop: got wr %b rd %b expected 0 0", writeport_wr, readport_rd); end
        checks++; if (host_req_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_ack_held: got %b expected 0", host_req_ready); end
        @(negedge clk);
        #1;
        checks++; if (host_req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_ack_fall: got %b expected 1", host_req_ready); end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        checks++; if (rsp_q.size() !== br || hs_q.size() - bh !== 2) begin errors++; $display("FAIL abort_no_rsp: got %0d rsp %0d hs expected 0 rsp 2 hs", rsp_q.size() - br, hs_q.size() - bh); end

        bh = hs_q.size();
        @(negedge clk);
        exp_q.push_back(exp_t'{1'b0, 32'h1357_9BDF});
        exp_q.push_back(exp_t'{1'b0, 32'h1357_9BDF});
        do_cmd(1'b0, 32'h0000_0300, 32'h0, t1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_read_accept: got no accept expected accept"); end
        do_cmd(1'b1, 32'h0000_0400, 32'hA5A5_5A5A, t2, ok);
        checks++; if (!ok || t2 - t1 !== 10) begin errors++; $display("FAIL b2b_accept_gap: got %0d expected 10", t2 - t1); end
        wait_rsp(br + 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_rsp: got %0d responses expected 2", rsp_q.size() - br); end
        if (ok) begin
            e = exp_q.pop_front();
            checks++; if (rsp_q[br].rdata !== e.rdata || rsp_q[br].err !== e.err) begin errors++; $display("FAIL b2b_read_data: got %h err %b expected %h err %b", rsp_q[br].rdata, rsp_q[br].err, e.rdata, e.err); end
            e = exp_q.pop_front();
            checks++; if (rsp_q[br+1].rdata !== e.rdata || rsp_q[br+1].err !== e.err) begin errors++; $display("FAIL b2b_write_hold: got %h err %b expected %h err %b", rsp_q[br+1].rdata, rsp_q[br+1].err, e.rdata, e.err); end
            checks++; if (int'(rsp_q[br].cyc) - t1 !== 9 || int'(rsp_q[br+1].cyc) - t2 !== 9) begin errors++; $display("FAIL b2b_latency: got %0d/%0d expected 9/9", int'(rsp_q[br].cyc) - t1, int'(rsp_q[br+1].cyc) - t2); end
        end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (rsp_q.size() - br !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", rsp_q.size() - br); end
        checks++;
        if (hs_q.size() - bh !== 4) begin
            errors++; $display("FAIL b2b_hs_count: got %0d expected 4", hs_q.size() - bh);
        end else begin
            if (hs_q[bh+2] !== hs_t'{1'b1, 32'h400, 32'h400, 16'hA5A5} || hs_q[bh+3] !== hs_t'{1'b1, 32'h401, 32'h401, 16'h5A5A}) begin
                errors++; $display("FAIL b2b_write_hs: got %h %h expected writes 400/A5A5 401/5A5A", hs_q[bh+2], hs_q[bh+3]);
            end
            checks++;
            if (hs_q[bh].is_wr !== 1'b0 || hs_q[bh].raddr !== 32'h300 || hs_q[bh+1].raddr !== 32'h301) begin
                errors++; $display("FAIL b2b_read_hs: got %h %h expected reads 300 301", hs_q[bh], hs_q[bh+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_late_ack();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_word_requester.md
# sdram_word_requester

Host-side requester for the 16-bit SDRAM controller's write/read ports. It accepts 32-bit word read and write commands from the cart-bus logic and splits each into two sequential 16-bit four-phase handshakes on the controller's `writeport_*` / `readport_*` interface, in big-endian order. It assembles read data, reports completion or timeout to the host, and never leaves a handshake half-finished.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 4096: maximum cycles spent waiting in any single handshake phase. 0 disables the timeout.

**Ports**
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `host_req_valid` in 1: host command valid.
- `host_req_ready` out 1: block can accept a command.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in 32: halfword address; bit 0 ignored (forced to 0).
- `host_wdata` in 32: write word.
- `host_rsp_valid` out 1: one-cycle completion pulse.
- `host_rsp_err` out 1: qualifies `host_rsp_valid`; 1 = timeout.
- `host_rdata` out 32: read word; valid with `host_rsp_valid`.
- `writeport_wr` out 1: write request.
- `writeport_addr` out 32: halfword address.
- `writeport_data` out 16: write halfword.
- `writeport_ack` in 1: write acknowledge.
- `readport_rd` out 1: read request.
- `readport_addr` out 32: halfword address.
- `readport_data` in 16: read halfword; valid while `readport_ack` = 1.
- `readport_ack` in 1: read acknowledge.

## Operation

**Command mapping**
- Latched base = `{host_addr[31:1], 1'b0}`.
- High half goes to base; low half goes to base|1.
- Write: `host_wdata[31:16]` to base, `host_wdata[15:0]` to base|1.
- Read: data from base goes to `host_rdata[31:16]`, data from base|1 goes to `host_rdata[15:0]`.
- `writeport_addr` and `readport_addr` are both driven with the current halfword address for every access, reads and writes alike.

**States:** IDLE, HI_REQ, HI_REL, LO_REQ, LO_REL, RESP, ERR, DRAIN.
- **IDLE:** `host_req_ready` = (`writeport_ack` == 0 && `readport_ack` == 0). On valid && ready, latch the address, `host_we` and `host_wdata`, then go to HI_REQ.
- **HI_REQ / LO_REQ:** assert `writeport_wr` (write) or `readport_rd` (read), with address and data stable. When the matching ack is sampled 1:
  - on a read, capture `readport_data` in that same cycle;
  - deassert the request and go to the matching *_REL state.
- **HI_REL:** request low. When the ack is sampled 0, go to LO_REQ.
- **LO_REL:** request low. When the ack is sampled 0, go to RESP.
- **RESP:** `host_rsp_valid` = 1 and `host_rsp_err` = 0 for one cycle, then IDLE.
- **Timeout:** a phase counter clears on entry to each *_REQ/*_REL state. If the counter reaches `TIMEOUT_CYCLES`-1 without the exit condition, go to ERR.
- **ERR:** request outputs 0. `host_rsp_valid` = 1, `host_rsp_err` = 1, `host_rdata` = 0 for one cycle, then DRAIN.
- **DRAIN:** stay until both acks are 0 (no timeout), then IDLE.
- Only one port request is ever high at a time. A request never rises while its ack is still 1.
- The counter width is $clog2(TIMEOUT_CYCLES)+1, saturating. Wrap is not allowed.

## Timing

**Reset values**
- State IDLE.
- `writeport_wr`, `readport_rd`, `host_rsp_valid`, `host_rsp_err` = 0.
- `host_rdata`, `writeport_addr`, `readport_addr`, `writeport_data` = 0.
- `host_req_ready` follows its IDLE decode.

**Output registration and reset**
- All outputs except `host_req_ready` are registered.
- A request asserts in the cycle after the state transition that calls for it.
- Reset mid-transaction drops requests immediately. If the controller still holds ack, `host_req_ready` stays 0 until the ack falls. No response is issued for the aborted command.

**Latency**
- With a responder whose ack follows the request with a 1-cycle lag, acceptance at cycle T gives `host_rsp_valid` at T+9 and `host_req_ready` again at T+10.
- Each extra cycle of ack latency adds one cycle.

**Host side**
- `host_req_valid` while ready = 0 is held by the host and not consumed.
- `host_rdata` holds its value until the next read completes.

## Test plan

- **Write:** `host_addr`=0x0000_1235, `host_wdata`=0xDEAD_BEEF, 1-cycle-lag ack model -> two write handshakes: 0x1234/0xDEAD, then 0x1235/0xBEEF. `host_rsp_valid` 9 cycles after accept, err = 0.
- **Read:** model returns 0xCAFE at 0x40 and 0xF00D at 0x41; read `host_addr`=0x40 -> `host_rdata`=0xCAFE_F00D. `readport_addr` = `writeport_addr` = 0x40 then 0x41.
- **Timeout:** `TIMEOUT_CYCLES`=8, ack never rises -> `readport_rd` high for exactly 8 cycles, then ERR pulse with err = 1 and rdata = 0, then IDLE. Covers DRAIN with ack 0.
- **Late ack:** ack rises 2 cycles after the timeout and is held 5 cycles -> ready stays 0 through DRAIN and rises the cycle after ack falls. No second response.
- **Reset and back-to-back:** `rst_n` pulsed low during LO_REQ of a write -> requests drop asynchronously, no response. Then back-to-back read and write commands are both completed in order, each with exactly one `host_rsp_valid` pulse.
